// File: rtl/utf8_decoder.sv
// Streaming UTF-8 decoder: one byte per cycle in, registered scalar value and status out.
// Define UTF8_DECODER_STRICT_EN to reject overlong, surrogate and >0x10FFFF second bytes.
// The data input is byte_i because 'byte' is a reserved SystemVerilog keyword.
module utf8_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        allow,
  input  logic        finish,
  input  logic [7:0]  byte_i,
  output logic [20:0] code_point,
  output logic [1:0]  status
);

  typedef enum logic [1:0] {IDLE, NEED1, NEED2, NEED3} state_t;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_CP   = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  state_t      state_q;
  logic [20:0] acc_q;
  logic [20:0] cp_q;
  logic [1:0]  status_q;
  logic        bad2;

  function automatic logic is_cont(input logic [7:0] b);
    return b[7:6] == 2'b10;
  endfunction

`ifdef UTF8_DECODER_STRICT_EN
  // Remembers which lead byte constrains the range of the following byte.
  typedef enum logic [2:0] {CHK_NONE, CHK_E0, CHK_ED, CHK_F0, CHK_F4} chk_t;
  chk_t chk_q;

  function automatic chk_t lead_chk(input logic [7:0] b);
    case (b)
      8'hE0:   return CHK_E0;
      8'hED:   return CHK_ED;
      8'hF0:   return CHK_F0;
      8'hF4:   return CHK_F4;
      default: return CHK_NONE;
    endcase
  endfunction

  function automatic logic second_bad(input chk_t c, input logic [7:0] b);
    case (c)
      CHK_E0:  return b < 8'hA0;
      CHK_ED:  return b > 8'h9F;
      CHK_F0:  return b < 8'h90;
      CHK_F4:  return b > 8'h8F;
      default: return 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
`ifdef UTF8_DECODER_STRICT_EN
    bad2 = second_bad(chk_q, byte_i);
`else
    bad2 = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cp_q     <= '0;
      status_q <= ST_NONE;
`ifdef UTF8_DECODER_STRICT_EN
      chk_q    <= CHK_NONE;
`endif
    end else begin
      status_q <= ST_NONE;
      if (finish) begin
        // End of stream outranks any byte presented in the same cycle.
        status_q <= (state_q == IDLE) ? ST_DONE : ST_ERR;
        state_q  <= IDLE;
        acc_q    <= '0;
`ifdef UTF8_DECODER_STRICT_EN
        chk_q    <= CHK_NONE;
`endif
      end else if (allow) begin
`ifdef UTF8_DECODER_STRICT_EN
        chk_q <= (state_q == IDLE) ? lead_chk(byte_i) : CHK_NONE;
`endif
        if (state_q == IDLE) begin
          if (!byte_i[7]) begin
            cp_q     <= {13'd0, byte_i};
            status_q <= ST_CP;
          end else if (byte_i inside {[8'hC2:8'hDF]}) begin
            acc_q   <= {16'd0, byte_i[4:0]};
            state_q <= NEED1;
          end else if (byte_i inside {[8'hE0:8'hEF]}) begin
            acc_q   <= {17'd0, byte_i[3:0]};
            state_q <= NEED2;
          end else if (byte_i inside {[8'hF0:8'hF4]}) begin
            acc_q   <= {18'd0, byte_i[2:0]};
            state_q <= NEED3;
          end else begin
            status_q <= ST_ERR;
          end
        end else if (!is_cont(byte_i) || bad2) begin
          status_q <= ST_ERR;
          state_q  <= IDLE;
          acc_q    <= '0;
        end else if (state_q == NEED1) begin
          cp_q     <= {acc_q[14:0], byte_i[5:0]};
          status_q <= ST_CP;
          state_q  <= IDLE;
          acc_q    <= '0;
        end else begin
          acc_q   <= {acc_q[14:0], byte_i[5:0]};
          state_q <= (state_q == NEED3) ? NEED2 : NEED1;
        end
      end
    end
  end

  assign code_point = cp_q;
  assign status     = status_q;

endmodule

// File: tb/tb_utf8_decoder.sv
// Randomised and directed bench for utf8_decoder against a sequence-level reference model.
module tb_utf8_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        allow = 1'b0;
  logic        finish = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [20:0] code_point;
  logic [1:0]  status;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes of the current sequence and how many are still due.
  int          rem = 0;
  logic [7:0]  seq[$];
  logic [20:0] m_cp = '0;
  logic [1:0]  m_st = '0;

  utf8_decoder dut (
    .clock      (clock),
    .reset      (reset),
    .allow      (allow),
    .finish     (finish),
    .byte_i     (din),
    .code_point (code_point),
    .status     (status)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] decode_seq();
    int unsigned v;
    int n;
    n = seq.size();
    v = (n == 2) ? (seq[0] & 8'h1F) : (n == 3) ? (seq[0] & 8'h0F) : (seq[0] & 8'h07);
    for (int i = 1; i < n; i++) v = v * 64 + (seq[i] & 8'h3F);
    return v[20:0];
  endfunction

  function automatic logic strict_bad(input logic [7:0] b);
`ifdef UTF8_DECODER_STRICT_EN
    if (seq.size() != 1) return 1'b0;
    if (seq[0] == 8'hE0 && b < 8'hA0) return 1'b1;
    if (seq[0] == 8'hED && b > 8'h9F) return 1'b1;
    if (seq[0] == 8'hF0 && b < 8'h90) return 1'b1;
    if (seq[0] == 8'hF4 && b > 8'h8F) return 1'b1;
    return 1'b0;
`else
    return (b == 8'hxx);
`endif
  endfunction

  task automatic model(input logic a, input logic f, input logic [7:0] b);
    m_st = 2'b00;
    if (f) begin
      m_st = (rem == 0) ? 2'b11 : 2'b10;
      rem = 0;
      seq.delete();
    end else if (a) begin
      if (rem == 0) begin
        if (b < 8'h80) begin
          m_cp = {13'd0, b};
          m_st = 2'b01;
        end else if (b >= 8'hC2 && b <= 8'hDF) begin
          rem = 1; seq = {b};
        end else if (b >= 8'hE0 && b <= 8'hEF) begin
          rem = 2; seq = {b};
        end else if (b >= 8'hF0 && b <= 8'hF4) begin
          rem = 3; seq = {b};
        end else begin
          m_st = 2'b10;
        end
      end else if (b < 8'h80 || b > 8'hBF || strict_bad(b)) begin
        m_st = 2'b10;
        rem = 0;
        seq.delete();
      end else begin
        seq.push_back(b);
        rem--;
        if (rem == 0) begin
          m_cp = decode_seq();
          m_st = 2'b01;
          seq.delete();
        end
      end
    end
  endtask

  task automatic step(input logic a, input logic f, input logic [7:0] b);
    @(negedge clock);
    allow = a; finish = f; din = b;
    @(posedge clock);
    #1;
    model(a, f, b);
    chk("status", {30'd0, status}, {30'd0, m_st});
    chk("code_point", {11'd0, code_point}, {11'd0, m_cp});
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, 1'b0, b);
  endtask

  task automatic do_reset();
    @(negedge clock);
    allow = 1'b0; finish = 1'b0;
    reset = 1'b0;
    #1;
    rem = 0; seq.delete(); m_cp = '0; m_st = 2'b00;
    chk("rst_status", {30'd0, status}, 32'd0);
    chk("rst_cp", {11'd0, code_point}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int r;
    logic [7:0] b;
    #12;
    chk("init_status", {30'd0, status}, 32'd0);
    chk("init_cp", {11'd0, code_point}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    send(8'hE2);
    do_reset();
    send(8'h41);
    chk("after_rst_41", {11'd0, code_point}, 32'h41);

    send(8'hC3); send(8'hA9);
    chk("e9", {11'd0, code_point}, 32'hE9);
    send(8'hE2); send(8'h82); send(8'hAC);
    chk("euro", {11'd0, code_point}, 32'h20AC);
    send(8'hF0); send(8'h9F); send(8'h98); send(8'h80);
    chk("emoji", {11'd0, code_point}, 32'h1F600);

    send(8'h80);
    chk("err_80", {30'd0, status}, 32'd2);
    send(8'hC0);
    chk("err_c0", {30'd0, status}, 32'd2);
    send(8'h41);

    send(8'hE2); send(8'h41);
    chk("err_e2_41_cp", {11'd0, code_point}, 32'h41);
    send(8'hE2); send(8'h82); step(1'b0, 1'b1, 8'h00);
    chk("trunc", {30'd0, status}, 32'd2);
    step(1'b0, 1'b1, 8'h00);
    chk("done", {30'd0, status}, 32'd3);

    send(8'hE2); send(8'h82);
    repeat (3) step(1'b0, 1'b0, 8'hFF);
    send(8'hAC);
    step(1'b1, 1'b1, 8'h41);
    chk("finish_wins", {11'd0, code_point}, 32'h20AC);

    send(8'hED); send(8'hA0); send(8'h80);
    send(8'hF4); send(8'h90); send(8'h80); send(8'h80);
    send(8'hE0); send(8'h9F); send(8'hBF);
    send(8'hF0); send(8'h8F); send(8'hBF); send(8'hBF);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 4) begin
        step($urandom_range(0, 1), 1'b1, 8'($urandom));
      end else if (r < 12) begin
        step(1'b0, 1'b0, 8'($urandom));
      end else begin
        if (rem == 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3: b = 8'($urandom_range(8'h00, 8'h7F));
            4:          b = 8'($urandom_range(8'hC2, 8'hDF));
            5:          b = 8'($urandom_range(8'hE0, 8'hEF));
            6:          b = 8'($urandom_range(8'hF0, 8'hF4));
            7:          b = 8'($urandom);
            8:          begin
                          r = $urandom_range(0, 3);
                          b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hED : (r == 2) ? 8'hF0 : 8'hF4;
                        end
            default:    b = 8'($urandom_range(8'h80, 8'hBF));
          endcase
        end else begin
          b = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(8'h80, 8'hBF)) : 8'($urandom);
        end
        send(b);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/utf8_decoder.md
UTF8_DECODER -- requirements
Module: utf8_decoder

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have port `clock`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port `allow`, input, 1 bit: `byte` is valid and consumed this cycle.
REQ-005 The block SHALL have port `finish`, input, 1 bit: end of input stream.
REQ-006 The block SHALL have port `byte`, input, 8 bits: next UTF-8 code unit.
REQ-007 The block SHALL have port `code_point`, output, 21 bits: last decoded scalar value.
REQ-008 The block SHALL have port `status`, output, 2 bits: 00 none, 01 code point valid, 10 error, 11 stream done.
REQ-009 All outputs SHALL be registered.

Function
REQ-010 The state machine SHALL have states IDLE, NEED1, NEED2, NEED3, where NEEDn means n continuation bytes remain.
REQ-011 In IDLE with `allow`=1:
- 0x00-0x7F: code_point=byte, status=01, stay in IDLE.
- 0xC2-0xDF: go to NEED1.
- 0xE0-0xEF: go to NEED2.
- 0xF0-0xF4: go to NEED3.
- 0x80-0xC1 and 0xF5-0xFF: status=10.
REQ-012 Lead-byte payload bits SHALL be accumulated (5, 4 or 3 bits); each continuation (10xxxxxx) SHALL shift in 6 bits and decrement NEEDn.
REQ-013 The final continuation SHALL produce code_point=accumulated value and status=01, and return to IDLE.
REQ-014 A non-continuation byte in NEEDn SHALL produce status=10 and return to IDLE; the offending byte is discarded, not reprocessed.
REQ-015 `status` SHALL be 01, 10 or 11 for exactly one cycle: the cycle after the triggering edge. Otherwise it is 00.
REQ-016 Latency from accepting the last byte of a sequence to status=01 SHALL be 1 cycle.
REQ-017 `code_point` SHALL change only when status becomes 01 and SHALL hold its value otherwise, including on error.
REQ-018 With `allow`=0 and `finish`=0, state and accumulator SHALL hold, and status SHALL return to 00.
REQ-019 `finish`=1 in IDLE SHALL produce status=11.
REQ-020 `finish`=1 in NEEDn (truncated sequence) SHALL produce status=10. In both cases the block returns to IDLE with the accumulator cleared.
REQ-021 When `finish` and `allow` are both 1 in the same cycle, `finish` SHALL win and `byte` is ignored.
REQ-022 After status 11 or 10 the block SHALL accept a new stream immediately, with no idle cycle required.

Reset
REQ-023 `reset`=0 SHALL asynchronously force: state=IDLE, accumulator=0, code_point=0, status=00.
REQ-024 Reset mid-sequence SHALL discard partial data with no error reported.
REQ-025 Deassertion SHALL take effect at the next rising edge of `clock`.

Configuration
REQ-026 Macro UTF8_DECODER_STRICT_EN defined SHALL enable semantic checks on the second byte, each reporting status=10 and returning to IDLE:
- After E0, second byte < 0xA0 (overlong).
- After ED, second byte > 0x9F (surrogate).
- After F0, second byte < 0x90 (overlong).
- After F4, second byte > 0x8F (above 0x10FFFF).
REQ-027 Macro UTF8_DECODER_STRICT_EN undefined SHALL perform only the structural checks of REQ-011/REQ-014. The listed sequences then decode arithmetically (e.g. ED A0 80 gives 0x00D800, status=01).

Verification
REQ-028 Apply reset=0 mid-sequence (after E2), then release, then send 41 -> status=01, code_point=0x000041 one cycle after 41.
REQ-029 Send C3 A9, then E2 82 AC, then F0 9F 98 80 -> status=01 with 0x0000E9, 0x0020AC, 0x01F600 respectively, 1 cycle after each final byte.
REQ-030 Send 80; separately, send C0 -> status=10 each time; then 41 -> status=01, 0x000041.
REQ-031 Send E2 41 -> status=10 on 41, code_point unchanged. Send E2 82 with finish=1 on the next cycle -> status=10. Send finish=1 in IDLE -> status=11.
REQ-032 Send E2 82, idle 3 cycles with allow=0, then AC -> status=01, 0x0020AC. Send allow=1 and finish=1 together -> status=11, byte ignored.
REQ-033 With UTF8_DECODER_STRICT_EN defined, send ED A0 80 and F4 90 80 80 -> status=10 at the second byte. Without the macro -> 0x00D800 and 0x110000, status=01.
